// File: rtl/ram_rd_control.sv
// ram_rd_control: streams NUM_ELEM 16-bit RAM words as 32-bit packed beats; define RD_CHECKSUM_EN for a trailing checksum beat
module ram_rd_control #(
  parameter logic [3:0] BASE_ADDR = 4'd0,
  parameter int         NUM_ELEM  = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ram_rd_en,
  output logic [3:0]  ram_rd_addr,
  input  logic [15:0] ram_rd_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_vld,
  output logic [31:0] out_data,
  input  logic        out_rdy,
  output logic        busy,
  output logic        done
);
  localparam int NB = (NUM_ELEM + 1) / 2;
  localparam logic [2:0] LAST = 3'(NB - 1);
`ifdef RD_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  typedef enum logic [2:0] {
    IDLE, RD_LO, RD_HI, CAP, SEND
`ifdef RD_CHECKSUM_EN
    , SUM
`endif
  } state_t;
  state_t      r_state;
  logic [2:0]  r_beat;
  logic [15:0] r_lo;
  logic        r_rd_en, r_sop, r_eop, r_vld, r_busy, r_done;
  logic [3:0]  r_addr;
  logic [31:0] r_data;
`ifdef RD_CHECKSUM_EN
  logic [19:0] r_sum;
`endif
  logic [3:0]  w_lo_addr, w_nxt_addr;
  logic [15:0] w_hi_data;
  logic        w_hi_ok, w_last;
  assign w_lo_addr  = BASE_ADDR + {r_beat, 1'b0};
  assign w_nxt_addr = BASE_ADDR + {r_beat + 3'd1, 1'b0};
  assign w_hi_ok    = 2 * int'(r_beat) + 1 < NUM_ELEM;
  assign w_last     = r_beat == LAST;
  assign w_hi_data  = w_hi_ok ? ram_rd_data : 16'h0000;
  assign ram_rd_en   = r_rd_en;
  assign ram_rd_addr = r_addr;
  assign out_sop     = r_sop;
  assign out_eop     = r_eop;
  assign out_vld     = r_vld;
  assign out_data    = r_data;
  assign busy        = r_busy;
  assign done        = r_done;
  // Beat sequencer: even read, odd read, capture, then hold the packed beat until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_lo    <= '0;
      r_rd_en <= 1'b0;
      r_addr  <= '0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_vld   <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef RD_CHECKSUM_EN
      r_sum   <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= RD_LO;
          r_busy  <= 1'b1;
          r_beat  <= '0;
          r_rd_en <= 1'b1;
          r_addr  <= BASE_ADDR;
`ifdef RD_CHECKSUM_EN
          r_sum   <= '0;
`endif
        end
        RD_LO: begin
          r_state <= RD_HI;
          r_rd_en <= w_hi_ok;
          r_addr  <= w_hi_ok ? w_lo_addr + 4'd1 : 4'd0;
        end
        RD_HI: begin
          r_state <= CAP;
          r_rd_en <= 1'b0;
          r_addr  <= '0;
          r_lo    <= ram_rd_data;
`ifdef RD_CHECKSUM_EN
          r_sum   <= r_sum + 20'(ram_rd_data);
`endif
        end
        CAP: begin
          r_state <= SEND;
          r_vld   <= 1'b1;
          r_data  <= {w_hi_data, r_lo};
          r_sop   <= r_beat == 3'd0;
          r_eop   <= w_last && !CSUM;
`ifdef RD_CHECKSUM_EN
          r_sum   <= r_sum + 20'(w_hi_data);
`endif
        end
        SEND: if (out_rdy) begin
          r_vld  <= 1'b0;
          r_data <= '0;
          r_sop  <= 1'b0;
          r_eop  <= 1'b0;
          if (!w_last) begin
            r_state <= RD_LO;
            r_beat  <= r_beat + 3'd1;
            r_rd_en <= 1'b1;
            r_addr  <= w_nxt_addr;
          end else begin
`ifdef RD_CHECKSUM_EN
            r_state <= SUM;
            r_vld   <= 1'b1;
            r_data  <= 32'(r_sum);
            r_eop   <= 1'b1;
`else
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef RD_CHECKSUM_EN
        SUM: if (out_rdy) begin
          r_state <= IDLE;
          r_vld   <= 1'b0;
          r_data  <= '0;
          r_eop   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_rd_control.sv
// tb_ram_rd_control: randomized self-checking bench for ram_rd_control against a packet-level model
module tb_ram_rd_control;
`ifdef RD_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif
  localparam int N  = 9;
  localparam int NB = (N + 1) / 2;
  logic clk = 0, rst = 1, start = 0, out_rdy = 1;
  logic rd_en, rd_en2, sop, sop2, eop, eop2, vld, vld2, busy, busy2, done, done2;
  logic [3:0] addr, addr2;
  logic [15:0] rd_data, rd_data2;
  logic [31:0] data, data2;
  logic [15:0] mem [16];
  int errors = 0, checks = 0, cyc = 0;

  ram_rd_control #(.BASE_ADDR(4'd0), .NUM_ELEM(N)) dut (
    .clk(clk), .rst(rst), .start(start), .ram_rd_en(rd_en), .ram_rd_addr(addr),
    .ram_rd_data(rd_data), .out_sop(sop), .out_eop(eop), .out_vld(vld), .out_data(data),
    .out_rdy(out_rdy), .busy(busy), .done(done));
  ram_rd_control #(.BASE_ADDR(4'd12), .NUM_ELEM(N)) dut12 (
    .clk(clk), .rst(rst), .start(start), .ram_rd_en(rd_en2), .ram_rd_addr(addr2),
    .ram_rd_data(rd_data2), .out_sop(sop2), .out_eop(eop2), .out_vld(vld2), .out_data(data2),
    .out_rdy(out_rdy), .busy(busy2), .done(done2));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data <= mem[addr];
    rd_data2 <= mem[addr2];
  end

  logic [31:0] g_data[$], e_data[$];
  bit g_sop[$], g_eop[$], e_sop[$], e_eop[$];
  int g_cyc[$], e_cyc[$], g_addr2[$];
  int rd_cnt, rd_cnt2, zviol, stab_viol, done_cyc, t0;
  bit timeout, busy_at_done;

  task automatic preload();
    for (int n = 0; n < 16; n++) mem[n] = 16'h1000 + 16'(n);
  endtask

  // packet model: pairs of elements packed {odd, even}, missing odd lane is zero
  task automatic build_exp();
    int sum;
    logic [15:0] lo, hi;
    sum = 0;
    e_data.delete(); e_sop.delete(); e_eop.delete(); e_cyc.delete();
    for (int k = 0; k < NB; k++) begin
      lo = mem[(2 * k) % 16];
      hi = (2 * k + 1 < N) ? mem[(2 * k + 1) % 16] : 16'h0000;
      sum += int'(lo) + int'(hi);
      e_data.push_back({hi, lo});
      e_sop.push_back(k == 0);
      e_eop.push_back(k == NB - 1 && CSUM == 0);
      e_cyc.push_back(4 + 4 * k);
    end
    if (CSUM == 1) begin
      e_data.push_back(32'(sum));
      e_sop.push_back(1'b0);
      e_eop.push_back(1'b1);
      e_cyc.push_back(4 + 4 * (NB - 1) + 1);
    end
  endtask

  // drives one start and records everything observed until done (no judging here)
  task automatic run(input int mode, input int restart_at, input int budget);
    logic [31:0] pd;
    bit ps, pe, stalled;
    stalled = 0; pd = 0; ps = 0; pe = 0;
    g_data.delete(); g_sop.delete(); g_eop.delete(); g_cyc.delete(); g_addr2.delete();
    rd_cnt = 0; rd_cnt2 = 0; zviol = 0; stab_viol = 0; done_cyc = -1; timeout = 1; busy_at_done = 1;
    @(posedge clk); #1;
    start = 1; out_rdy = 1; t0 = cyc;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rd_en) rd_cnt++; else if (addr != 4'd0) zviol++;
      if (rd_en2) begin rd_cnt2++; g_addr2.push_back(int'(addr2)); end
      if (!vld && data != 32'd0) zviol++;
      if (stalled && (!vld || data !== pd || sop !== ps || eop !== pe)) stab_viol++;
      stalled = vld && !out_rdy; pd = data; ps = sop; pe = eop;
      if (vld && out_rdy) begin
        g_data.push_back(data); g_sop.push_back(sop); g_eop.push_back(eop); g_cyc.push_back(cyc - t0);
      end
      if (done) begin done_cyc = cyc - t0; busy_at_done = busy; timeout = 0; break; end
      @(posedge clk); #1;
      start = (i + 1 == restart_at);
      out_rdy = (mode == 1) ? !(i + 1 >= 8 && i + 1 <= 10) : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    out_rdy = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({rd_en, addr, sop, eop, vld, data, busy, done} !== '0)
      $display("FAIL reset_outputs: got en=%b addr=%0d vld=%b data=%h busy=%b done=%b, expected all 0", rd_en, addr, vld, data, busy, done);
    @(posedge clk); #1 rst = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd_en, vld, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got en=%b vld=%b busy=%b done=%b, expected 0", rd_en, vld, busy, done);
    end
  endtask

  task automatic test_basic();
    preload(); build_exp();
    run(0, -1, 60);
    checks++; if (timeout) begin errors++; $display("FAIL basic_timeout: got no done, expected done"); end
    checks++; if (g_data.size() != e_data.size()) begin errors++; $display("FAIL basic_beats: got %0d expected %0d", g_data.size(), e_data.size()); end
    for (int k = 0; k < e_data.size() && k < g_data.size(); k++) begin
      checks++;
      if ({g_data[k], g_sop[k], g_eop[k]} !== {e_data[k], e_sop[k], e_eop[k]}) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h sop=%b eop=%b expected %h sop=%b eop=%b", k, g_data[k], g_sop[k], g_eop[k], e_data[k], e_sop[k], e_eop[k]);
      end
      checks++;
      if (g_cyc[k] != e_cyc[k]) begin errors++; $display("FAIL basic_cycle%0d: got T+%0d expected T+%0d", k, g_cyc[k], e_cyc[k]); end
    end
    checks++; if (done_cyc != e_cyc[e_cyc.size() - 1] + 1 || busy_at_done) begin errors++; $display("FAIL basic_done: got T+%0d busy=%b expected T+%0d busy=0", done_cyc, busy_at_done, e_cyc[e_cyc.size() - 1] + 1); end
    checks++; if (rd_cnt != N || zviol != 0) begin errors++; $display("FAIL basic_reads: got rd=%0d zviol=%0d expected rd=%0d zviol=0", rd_cnt, zviol, N); end
  endtask

  task automatic test_stall();
    preload(); build_exp();
    run(1, -1, 80);
    checks++; if (timeout || g_data.size() != e_data.size()) begin errors++; $display("FAIL stall_beats: got %0d timeout=%b expected %0d", g_data.size(), timeout, e_data.size()); end
    else begin
      checks++; if (g_data[1] !== 32'h1003_1002 || g_cyc[1] != 11) begin errors++; $display("FAIL stall_beat1: got %h at T+%0d expected 10031002 at T+11", g_data[1], g_cyc[1]); end
      for (int k = 0; k < e_data.size(); k++) begin
        checks++;
        if ({g_data[k], g_sop[k], g_eop[k]} !== {e_data[k], e_sop[k], e_eop[k]}) begin errors++; $display("FAIL stall_beat%0d: got %h expected %h", k, g_data[k], e_data[k]); end
      end
    end
    checks++; if (stab_viol != 0 || rd_cnt != N) begin errors++; $display("FAIL stall_hold: got unstable=%0d rd=%0d expected 0 and %0d", stab_viol, rd_cnt, N); end
  endtask

  task automatic test_restart_ignored();
    int extra;
    preload(); build_exp();
    run(0, 6, 60);
    checks++; if (timeout || g_data.size() != e_data.size() || g_data[0] !== e_data[0]) begin errors++; $display("FAIL restart_packet: got %0d beats timeout=%b expected %0d", g_data.size(), timeout, e_data.size()); end
    checks++; if (rd_cnt != N) begin errors++; $display("FAIL restart_reads: got %0d expected %0d", rd_cnt, N); end
    extra = 0;
    repeat (10) begin @(negedge clk); if (vld || rd_en || busy) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL restart_second_packet: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back();
    int beats;
    bit ok;
    preload(); build_exp();
    run(0, 4 * NB + 1 + CSUM, 60);
    checks++; if (timeout || busy_at_done || done_cyc != 4 * NB + 1 + CSUM) begin errors++; $display("FAIL b2b_done: got T+%0d busy=%b expected T+%0d busy=0", done_cyc, busy_at_done, 4 * NB + 1 + CSUM); end
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    checks++; if (!(busy && rd_en && addr == 4'd0)) begin errors++; $display("FAIL b2b_accept: got busy=%b en=%b addr=%0d expected 1 1 0", busy, rd_en, addr); end
    beats = 0; ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (vld && out_rdy) beats++;
      ok = done;
    end
    checks++; if (!ok || beats != e_data.size()) begin errors++; $display("FAIL b2b_second: got %0d beats done=%b expected %0d", beats, ok, e_data.size()); end
  endtask

  task automatic test_reset_mid();
    preload(); build_exp();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    checks++; if (!vld || data !== 32'h1005_1004) begin errors++; $display("FAIL midrst_beat2: got vld=%b %h expected 1 10051004", vld, data); end
    #1 rst = 1;
    #1;
    checks++;
    if ({rd_en, addr, sop, eop, vld, data, busy, done} !== '0) begin
      errors++;
      $display("FAIL midrst_async: got en=%b vld=%b data=%h busy=%b expected all 0", rd_en, vld, data, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(negedge clk);
    checks++; if (vld || busy) begin errors++; $display("FAIL midrst_resume: got vld=%b busy=%b expected 0 0", vld, busy); end
    run(0, -1, 60);
    checks++; if (timeout || g_data.size() != e_data.size() || g_data[0] !== 32'h1001_1000 || !g_sop[0]) begin errors++; $display("FAIL midrst_fresh: got %0d beats first=%h expected %0d beats first=10011000 sop=1", g_data.size(), g_data.size() ? g_data[0] : 32'hx, e_data.size()); end
  endtask

  task automatic test_base_addr();
    int exp_a;
    preload();
    run(0, -1, 60);
    checks++; if (rd_cnt2 != N) begin errors++; $display("FAIL base_count: got %0d expected %0d", rd_cnt2, N); end
    for (int i = 0; i < N && i < g_addr2.size(); i++) begin
      exp_a = (12 + i) % 16;
      checks++;
      if (g_addr2[i] != exp_a) begin errors++; $display("FAIL base_addr%0d: got %0d expected %0d", i, g_addr2[i], exp_a); end
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 4; p++) begin
      for (int n = 0; n < 16; n++) mem[n] = 16'($urandom);
      build_exp();
      run(2, -1, 400);
      checks++; if (timeout || g_data.size() != e_data.size()) begin errors++; $display("FAIL rand%0d_beats: got %0d timeout=%b expected %0d", p, g_data.size(), timeout, e_data.size()); end
      for (int k = 0; k < e_data.size() && k < g_data.size(); k++) begin
        checks++;
        if ({g_data[k], g_sop[k], g_eop[k]} !== {e_data[k], e_sop[k], e_eop[k]}) begin errors++; $display("FAIL rand%0d_beat%0d: got %h sop=%b eop=%b expected %h sop=%b eop=%b", p, k, g_data[k], g_sop[k], g_eop[k], e_data[k], e_sop[k], e_eop[k]); end
      end
      checks++; if (rd_cnt != N || zviol != 0 || stab_viol != 0) begin errors++; $display("FAIL rand%0d_rules: got rd=%0d zviol=%0d unstable=%0d expected %0d 0 0", p, rd_cnt, zviol, stab_viol, N); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    preload();
    test_reset();
    test_basic();
    test_stall();
    test_restart_ignored();
    test_back_to_back();
    test_reset_mid();
    test_base_addr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ram_rd_control.md
RAM_RD_CONTROL -- requirements
Module: ram_rd_control

Interface
REQ-001 Parameter: BASE_ADDR, default 4'd0, RAM word address of matrix element 0.
REQ-002 Parameter: NUM_ELEM, default 9, number of 16-bit matrix elements read per packet (legal range 1..16).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to read out one complete matrix.
REQ-006 ram_rd_en  output  1  RAM read strobe.
REQ-007 ram_rd_addr  output  4  RAM read word address.
REQ-008 ram_rd_data  input  16  RAM read data, valid the cycle after ram_rd_en.
REQ-009 out_sop / out_eop / out_vld  output  1 each  output packet start, end and beat valid.
REQ-010 out_data  output  32  output beat payload.
REQ-011 out_rdy  input  1  downstream accept; beat transfers when out_vld && out_rdy.
REQ-012 busy  output  1  high from start acceptance until the cycle after the eop transfer.
REQ-013 done  output  1  one-cycle pulse in the cycle after the eop transfer.

Function
REQ-014 FSM states are IDLE, RD_LO, RD_HI, CAP, SEND and (macro only) SUM; all outputs are registered.
REQ-015 In IDLE, start=1 moves the FSM to RD_LO; start is ignored in every other state.
REQ-016 Beat k (k=0..ceil(NUM_ELEM/2)-1) reads element 2k in RD_LO and element 2k+1 in RD_HI, at address BASE_ADDR+index mod 16 (4-bit wrap).
REQ-017 In RD_HI, when 2k+1 >= NUM_ELEM, ram_rd_en stays 0 and the high lane is forced to 16'h0000.
REQ-018 CAP captures the second read word; out_data = {element 2k+1, element 2k}, low lane = even element.
REQ-019 In SEND, out_vld=1; out_data, out_sop and out_eop are held stable until out_rdy=1.
REQ-020 On a SEND transfer: if more beats remain, go to RD_LO; otherwise go to IDLE, or to SUM when the macro is defined.
REQ-021 With out_rdy held high, start is sampled at edge T, beat 0 is valid in cycle T+4, and successive beats are spaced 4 cycles apart.
REQ-022 out_sop=1 only on beat 0; out_eop=1 only on the final beat of the packet.
REQ-023 ram_rd_en is high for exactly NUM_ELEM cycles per packet; ram_rd_addr=0 whenever ram_rd_en=0.
REQ-024 out_data=0 whenever out_vld=0.
REQ-025 done and busy deassertion occur in the same cycle, the cycle after the eop transfer; a start in that cycle is accepted.

Reset
REQ-026 rst=1 forces the FSM to IDLE and every output to 0 immediately, regardless of clk, including mid-packet.
REQ-027 A packet interrupted by reset is abandoned and never resumed; the first start after rst falls begins a fresh packet at beat 0.

Configuration
REQ-028 Macro RD_CHECKSUM_EN: when defined, after the last element beat the FSM enters SUM.
REQ-029 SUM emits one extra beat whose out_data is the 32-bit zero-extended sum of all NUM_ELEM elements, with out_eop=1 on that beat; with out_rdy held high the SUM beat follows the preceding beat transfer by 1 cycle.
REQ-030 When RD_CHECKSUM_EN is not defined, there is no SUM state and no sum accumulator, and eop is on the last element beat.

Verification
REQ-031 RAM preloaded with addr n = 16'h1000+n, NUM_ELEM=9, out_rdy=1, start at edge T -> 5 beats at T+4, T+8 ... T+20: 32'h1001_1000, 32'h1003_1002, 32'h1005_1004, 32'h1007_1006, 32'h0000_1008; sop on beat 0 only, eop on beat 4 only, done pulses at T+21.
REQ-032 Same preload, out_rdy held low for 3 cycles during beat 1 -> 32'h1003_1002 and out_vld held stable for 4 cycles; no extra ram_rd_en pulses; total ram_rd_en count is 9.
REQ-033 start pulsed again at T+6 while busy -> ignored; exactly one 5-beat packet is produced.
REQ-034 rst asserted during beat 2 SEND -> all outputs go to 0 asynchronously; a start after release yields a full packet starting with 32'h1001_1000 and sop=1.
REQ-035 RD_CHECKSUM_EN defined, same preload -> a 6th beat with out_data = 32'h0000_9024 and eop=1; beat 4 has eop=0.
REQ-036 BASE_ADDR=4'd12, NUM_ELEM=9 -> ram_rd_addr sequence 12,13,14,15,0,1,2,3,4.
